music_beat_sequencer: RTL and testbench

- Transport controller that sequences the beat-indexed tone/LED lookup block.
- Generates the 12-bit beat index and the play-enable that the lookup block consumes.
- Provides play/pause/stop control, selectable tempo, loop or one-shot playback, and an end-of-pattern pulse.
- Sits between the button/switch front end (debounced one-cycle pulses) and the tone lookup; its outputs drive the lookup's beat-number and enable inputs directly.

---
 rtl/music_beat_sequencer_pkg.sv | 16 +
 rtl/music_beat_sequencer_if.sv | 32 +++
 rtl/music_beat_sequencer_beat_divider.sv | 49 ++++
 rtl/music_beat_sequencer.sv | 127 ++++++++++++
 tb/tb_music_beat_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/music_beat_sequencer_pkg.sv
// Shared constants for the beat sequencer: FSM state codes, tempo select codes, beat index width.
package music_pkg;

  localparam int unsigned BEAT_W = 12;

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  // Beat period multiplier relative to BASE_DIV: x2, x1, x1/2, x1/4
  localparam logic [1:0] TEMPO_SLOW    = 2'd0;
  localparam logic [1:0] TEMPO_BASE    = 2'd1;
  localparam logic [1:0] TEMPO_FAST    = 2'd2;
  localparam logic [1:0] TEMPO_FASTEST = 2'd3;

endpackage

// File: rtl/music_beat_sequencer_if.sv
// Control/status bundle between the button front end, the sequencer and the tone lookup.
// MUSIC_STEP_EN adds the single-step pulse used while paused.
interface music_beat_sequencer_if;
  import music_pkg::*;

  logic              play;
  logic              pause;
  logic              stop;
  logic              loop_en;
  logic [1:0]        tempo_sel;
`ifdef MUSIC_STEP_EN
  logic              step;
`endif
  logic [BEAT_W-1:0] beat_num;
  logic              en;
  logic              beat_tick;
  logic              done;
  logic [1:0]        state_o;

`ifdef MUSIC_STEP_EN
  modport master (output play, pause, stop, loop_en, tempo_sel, step,
                  input  beat_num, en, beat_tick, done, state_o);
  modport slave  (input  play, pause, stop, loop_en, tempo_sel, step,
                  output beat_num, en, beat_tick, done, state_o);
`else
  modport master (output play, pause, stop, loop_en, tempo_sel,
                  input  beat_num, en, beat_tick, done, state_o);
  modport slave  (input  play, pause, stop, loop_en, tempo_sel,
                  output beat_num, en, beat_tick, done, state_o);
`endif

endinterface

// File: rtl/music_beat_sequencer_beat_divider.sv
// Beat-period divider: counts clk cycles while running and flags the last cycle of each beat.
module beat_divider
  import music_pkg::*;
#(
  parameter int unsigned BASE_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_clear,
  input  logic [1:0] i_tempo_sel,
  output logic       o_tick_c
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_limit;
  logic             w_wrap;

  // Period from tempo select, shifts only
  always_comb begin
    w_period = BASE;
    case (i_tempo_sel)
      TEMPO_SLOW: w_period = BASE << 1;
      TEMPO_BASE: w_period = BASE;
      TEMPO_FAST: w_period = BASE >> 1;
      default:    w_period = BASE >> 2;
    endcase
  end

  // >= compare so a tempo speed-up past the current count ticks immediately
  assign w_limit  = w_period - CNT_W'(1);
  assign w_wrap   = (r_cnt >= w_limit);
  assign o_tick_c = i_run & ~i_clear & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_beat_sequencer.sv
// Transport controller producing beat index and play enable for the tone lookup.
// Optional MUSIC_STEP_EN: single-step the beat while paused.
module music_beat_sequencer
  import music_pkg::*;
#(
  parameter int unsigned BASE_DIV = 25_000_000,
  parameter int unsigned BEAT_LEN = 64,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  music_beat_sequencer_if.slave bus
);

  logic [1:0]        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic              r_en;
  logic              r_tick;
  logic              r_done;

  logic [1:0]        w_state_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              w_tick_nxt;
  logic              w_done_nxt;
  logic              w_cmd_stop;
  logic              w_cmd_pause;
  logic              w_cmd_play;
  logic              w_run;
  logic              w_clear;
  logic              w_step_go;
  logic              w_div_tick;
  logic              w_adv;
  logic              w_last;

  // Resolve coincident pulses: stop > pause > play
  assign w_cmd_stop  = bus.stop;
  assign w_cmd_pause = bus.pause & ~bus.stop;
  assign w_cmd_play  = bus.play & ~bus.pause & ~bus.stop;

`ifdef MUSIC_STEP_EN
  assign w_step_go = (r_state == ST_PAUSE) & bus.step & ~bus.stop & ~bus.pause & ~bus.play;
`else
  assign w_step_go = 1'b0;
`endif

  assign w_run   = (r_state == ST_PLAY) & ~bus.stop & ~bus.pause;
  assign w_clear = ((r_state != ST_PLAY) & (r_state != ST_PAUSE)) | w_cmd_stop | w_step_go;
  assign w_adv   = w_div_tick | w_step_go;
  assign w_last  = (r_beat == BEAT_W'(BEAT_LEN - 1));

  beat_divider #(
    .BASE_DIV (BASE_DIV),
    .CNT_W    (CNT_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .i_clear     (w_clear),
    .i_tempo_sel (bus.tempo_sel),
    .o_tick_c    (w_div_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (w_cmd_stop) begin
          w_state_nxt = ST_STOP;
          w_beat_nxt  = '0;
        end else if (w_cmd_pause) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_cmd_stop) begin
          w_state_nxt = ST_STOP;
          w_beat_nxt  = '0;
        end else if (w_cmd_play) begin
          w_state_nxt = ST_PLAY;
        end
      end
      default: begin
        w_beat_nxt  = '0;
        w_state_nxt = w_cmd_play ? ST_PLAY : ST_STOP;
      end
    endcase
    // Beat advance from a divider tick or a step; terminal beat wraps and may end a one-shot
    if (w_adv) begin
      w_tick_nxt = 1'b1;
      if (w_last) begin
        w_done_nxt = 1'b1;
        w_beat_nxt = '0;
        if (!bus.loop_en) begin
          w_state_nxt = ST_STOP;
        end
      end else begin
        w_beat_nxt = r_beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STOP;
      r_beat  <= '0;
      r_en    <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_en    <= (w_state_nxt == ST_PLAY);
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.beat_num  = r_beat;
  assign bus.en        = r_en;
  assign bus.beat_tick = r_tick;
  assign bus.done      = r_done;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_music_beat_sequencer.sv
// Self-checking bench for music_beat_sequencer: directed scenarios plus random pulses vs a cycle model.
module tb_music_beat_sequencer;

  localparam int BASE_DIV = 8;
  localparam int BEAT_LEN = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  music_beat_sequencer_if bus ();

  music_beat_sequencer #(
    .BASE_DIV (BASE_DIV),
    .BEAT_LEN (BEAT_LEN),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: state 0 stop / 1 play / 2 pause, phase = cycles elapsed in current beat
  int m_state, m_beat, m_phase;
  bit m_tick, m_done;

  always @(posedge clk or negedge rst_n) begin : model
    int period;
    int cmd;
    bit adv;
    bit stp;
    if (!rst_n) begin
      m_state = 0; m_beat = 0; m_phase = 0; m_tick = 0; m_done = 0;
    end else begin
      period = (2 * BASE_DIV) >> bus.tempo_sel;
      cmd = bus.stop ? 3 : (bus.pause ? 2 : (bus.play ? 1 : 0));
`ifdef MUSIC_STEP_EN
      stp = bus.step;
`else
      stp = 1'b0;
`endif
      adv = 1'b0; m_tick = 1'b0; m_done = 1'b0;
      if (m_state == 0) begin
        if (cmd == 1) m_state = 1;
      end else if (m_state == 1) begin
        if (cmd == 3) begin m_state = 0; m_beat = 0; m_phase = 0; end
        else if (cmd == 2) m_state = 2;
        else if (m_phase + 1 >= period) begin m_phase = 0; adv = 1'b1; end
        else m_phase = m_phase + 1;
      end else begin
        if (cmd == 3) begin m_state = 0; m_beat = 0; m_phase = 0; end
        else if (cmd == 1) m_state = 1;
        else if (cmd == 0 && stp) begin m_phase = 0; adv = 1'b1; end
      end
      if (adv) begin
        m_tick = 1'b1;
        if (m_beat == BEAT_LEN - 1) begin
          m_done = 1'b1;
          m_beat = 0;
          if (!bus.loop_en) m_state = 0;
        end else begin
          m_beat = m_beat + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input bit s, input bit p, input bit pl);
    bus.stop = s; bus.pause = p; bus.play = pl;
    cyc();
    bus.stop = 1'b0; bus.pause = 1'b0; bus.play = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.loop_en = 1'b1; bus.tempo_sel = 2'd1;
`ifdef MUSIC_STEP_EN
    bus.step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.state_o); end
    n_checks++; if (bus.beat_num !== 12'd0) begin n_fail++; $display("FAIL reset_beat got %0d exp 0", bus.beat_num); end
    n_checks++; if (bus.en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %0b exp 0", bus.en); end
    n_checks++; if (bus.beat_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %0b exp 0", bus.beat_tick); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_loop_play();
    bus.loop_en = 1'b1; bus.tempo_sel = 2'd1;
    pulse(1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.en !== 1'b1) begin n_fail++; $display("FAIL loop_en_after_play got %0b exp 1", bus.en); end
    n_checks++; if (bus.state_o !== 2'b01) begin n_fail++; $display("FAIL loop_state got %0d exp 1", bus.state_o); end
    for (int k = 1; k <= 32; k++) begin
      cyc();
      n_checks++; if (bus.beat_tick !== (k % 8 == 0)) begin n_fail++; $display("FAIL loop_tick k=%0d got %0b exp %0b", k, bus.beat_tick, (k % 8 == 0)); end
      n_checks++; if (bus.beat_num !== 12'((k / 8) % 4)) begin n_fail++; $display("FAIL loop_beat k=%0d got %0d exp %0d", k, bus.beat_num, (k / 8) % 4); end
      n_checks++; if (bus.done !== (k == 32)) begin n_fail++; $display("FAIL loop_done k=%0d got %0b exp %0b", k, bus.done, (k == 32)); end
    end
  endtask

  task automatic test_one_shot();
    pulse(1'b1, 1'b0, 1'b0);
    bus.loop_en = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k == 31) begin
        n_checks++; if (bus.en !== 1'b1) begin n_fail++; $display("FAIL oneshot_en_before_end got %0b exp 1", bus.en); end
      end
    end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL oneshot_done got %0b exp 1", bus.done); end
    n_checks++; if (bus.beat_num !== 12'd0) begin n_fail++; $display("FAIL oneshot_beat got %0d exp 0", bus.beat_num); end
    n_checks++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL oneshot_state got %0d exp 0", bus.state_o); end
    n_checks++; if (bus.en !== 1'b0) begin n_fail++; $display("FAIL oneshot_en got %0b exp 0", bus.en); end
    cyc();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL oneshot_done_single got %0b exp 0", bus.done); end
    bus.loop_en = 1'b1;
  endtask

  task automatic test_pause_resume();
    pulse(1'b0, 1'b0, 1'b1);
    repeat (21) cyc();
    pulse(1'b0, 1'b1, 1'b0);
    n_checks++; if (bus.state_o !== 2'b10) begin n_fail++; $display("FAIL pause_state got %0d exp 2", bus.state_o); end
    n_checks++; if (bus.en !== 1'b0) begin n_fail++; $display("FAIL pause_en got %0b exp 0", bus.en); end
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_checks++; if (bus.beat_num !== 12'd2 || bus.beat_tick !== 1'b0) begin n_fail++; $display("FAIL pause_hold k=%0d beat %0d tick %0b exp beat 2 tick 0", k, bus.beat_num, bus.beat_tick); end
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.state_o !== 2'b01 || bus.en !== 1'b1) begin n_fail++; $display("FAIL resume_state got %0d en %0b exp 1 en 1", bus.state_o, bus.en); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_checks++; if (bus.beat_tick !== (k == 3)) begin n_fail++; $display("FAIL resume_tick k=%0d got %0b exp %0b", k, bus.beat_tick, (k == 3)); end
    end
    n_checks++; if (bus.beat_num !== 12'd3) begin n_fail++; $display("FAIL resume_beat got %0d exp 3", bus.beat_num); end
  endtask

  task automatic test_coincident();
    pulse(1'b1, 1'b1, 1'b1);
    n_checks++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL all3_state got %0d exp 0", bus.state_o); end
    n_checks++; if (bus.beat_num !== 12'd0) begin n_fail++; $display("FAIL all3_beat got %0d exp 0", bus.beat_num); end
    n_checks++; if (bus.done !== 1'b0 || bus.en !== 1'b0) begin n_fail++; $display("FAIL all3_done_en got done %0b en %0b exp 0 0", bus.done, bus.en); end
    pulse(1'b0, 1'b0, 1'b1);
    repeat (31) cyc();
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL stop_on_last_done got %0b exp 0", bus.done); end
    n_checks++; if (bus.beat_tick !== 1'b0) begin n_fail++; $display("FAIL stop_on_last_tick got %0b exp 0", bus.beat_tick); end
    n_checks++; if (bus.beat_num !== 12'd0 || bus.state_o !== 2'b00) begin n_fail++; $display("FAIL stop_on_last_pos got beat %0d state %0d exp 0 0", bus.beat_num, bus.state_o); end
  endtask

  task automatic test_tempo_change();
    bus.tempo_sel = 2'd0;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (10) cyc();
    bus.tempo_sel = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      n_checks++; if (bus.beat_tick !== (k % 2 == 1)) begin n_fail++; $display("FAIL tempo_tick k=%0d got %0b exp %0b", k, bus.beat_tick, (k % 2 == 1)); end
      n_checks++; if (bus.beat_num !== 12'((k + 1) / 2)) begin n_fail++; $display("FAIL tempo_beat k=%0d got %0d exp %0d", k, bus.beat_num, (k + 1) / 2); end
    end
    pulse(1'b1, 1'b0, 1'b0);
    bus.tempo_sel = 2'd1;
  endtask

`ifdef MUSIC_STEP_EN
  task automatic test_step();
    bus.loop_en = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (24) cyc();
    pulse(1'b0, 1'b1, 1'b0);
    n_checks++; if (bus.state_o !== 2'b10 || bus.beat_num !== 12'd3) begin n_fail++; $display("FAIL step_pre got state %0d beat %0d exp 2 3", bus.state_o, bus.beat_num); end
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    n_checks++; if (bus.done !== 1'b1 || bus.beat_tick !== 1'b1) begin n_fail++; $display("FAIL step_done_tick got %0b %0b exp 1 1", bus.done, bus.beat_tick); end
    n_checks++; if (bus.state_o !== 2'b00 || bus.beat_num !== 12'd0) begin n_fail++; $display("FAIL step_wrap got state %0d beat %0d exp 0 0", bus.state_o, bus.beat_num); end
    n_checks++; if (bus.en !== 1'b0) begin n_fail++; $display("FAIL step_en got %0b exp 0", bus.en); end
    bus.loop_en = 1'b1;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.play  = ($urandom_range(19) == 0);
      bus.pause = ($urandom_range(39) == 0);
      bus.stop  = ($urandom_range(79) == 0);
`ifdef MUSIC_STEP_EN
      bus.step  = ($urandom_range(9) == 0);
`endif
      if ($urandom_range(99) == 0) bus.loop_en = ~bus.loop_en;
      if ($urandom_range(63) == 0) bus.tempo_sel = 2'($urandom_range(3));
      cyc();
      n_checks++; if (bus.state_o !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state i=%0d got %0d exp %0d", i, bus.state_o, m_state); end
      n_checks++; if (bus.beat_num !== 12'(m_beat)) begin n_fail++; $display("FAIL rnd_beat i=%0d got %0d exp %0d", i, bus.beat_num, m_beat); end
      n_checks++; if (bus.en !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_en i=%0d got %0b exp %0b", i, bus.en, (m_state == 1)); end
      n_checks++; if (bus.beat_tick !== m_tick) begin n_fail++; $display("FAIL rnd_tick i=%0d got %0b exp %0b", i, bus.beat_tick, m_tick); end
      n_checks++; if (bus.done !== m_done) begin n_fail++; $display("FAIL rnd_done i=%0d got %0b exp %0b", i, bus.done, m_done); end
    end
    bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
`ifdef MUSIC_STEP_EN
    bus.step = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_loop_play();
    test_one_shot();
    test_pause_resume();
    test_coincident();
    test_tempo_change();
`ifdef MUSIC_STEP_EN
    test_step();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
